// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver feeding a show-ahead FIFO; byte visible 2 sync + 1 cycles after the pin stop-bit midpoint.
// No backpressure: a good byte arriving at a full buffer without a same-cycle pop is dropped and flags overrun.
module uart_rx_buf #(
    parameter int BAUD_CYCLE = 868,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rstB,
    input  logic                     rx,
    input  logic                     rdEn,
    output logic [7:0]               rdData,
    output logic                     ffEmpty,
    output logic                     ffFull,
    output logic [$clog2(DEPTH):0]   ffCount,
    input  logic                     errClr,
    output logic                     frameErr,
    output logic                     overrun
);
    localparam int CW = $clog2(BAUD_CYCLE);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_CYCLE - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, rxs_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic            frame_err_q, overrun_q;

    logic            baud_tick, shift_en, push_req, ferr_set;
    logic            pop, push_ok, ovr_set;

    // State register
    always_ff @(posedge clk) begin
        if (!rstB) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rxs_q) state_d = START;
            START:   if (baud_tick) state_d = rxs_q ? IDLE : DATA;
            DATA:    if (baud_tick && bit_q == 3'd7) state_d = STOP;
            STOP:    if (baud_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the start bit uses a half-bit count, every other phase a full bit
    always_comb begin
        baud_tick = (state_q == START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);
        shift_en  = (state_q == DATA) && baud_tick;
        push_req  = (state_q == STOP) && baud_tick && rxs_q;
        ferr_set  = (state_q == STOP) && baud_tick && !rxs_q;
    end

    always_comb begin
        cnt_d   = (state_q == IDLE || baud_tick) ? '0 : cnt_q + CW'(1);
        bit_d   = (state_q == START) ? 3'd0 : (shift_en ? bit_q + 3'd1 : bit_q);
        shift_d = shift_en ? {rxs_q, shift_q[7:1]} : shift_q;
    end

    // A slot freed by a same-cycle pop lets a push into a full buffer
    always_comb begin
        pop     = rdEn && (count_q != '0);
        push_ok = push_req && ((count_q != FULL_CNT) || pop);
        ovr_set = push_req && !push_ok;
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!push_ok && pop) count_d = count_q - (AW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstB) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rxs_q       <= sync1_q;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            frame_err_q <= ferr_set | (frame_err_q & ~errClr);
            overrun_q   <= ovr_set  | (overrun_q   & ~errClr);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rdData   = mem_q[rd_ptr_q];
    assign ffCount  = count_q;
    assign ffEmpty  = (count_q == '0);
    assign ffFull   = (count_q == FULL_CNT);
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf: frames driven on rx, popped bytes scored against an expected-byte queue.
module tb_uart_rx_buf;
    localparam int B = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rstB = 1'b0;
    logic       rx = 1'b1;
    logic       rdEn = 1'b0;
    logic       errClr = 1'b0;
    logic [7:0] rdData;
    logic       ffEmpty, ffFull, frameErr, overrun;
    logic [2:0] ffCount;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    uart_rx_buf #(.BAUD_CYCLE(B), .DEPTH(D)) dut (
        .clk(clk), .rstB(rstB), .rx(rx), .rdEn(rdEn), .rdData(rdData),
        .ffEmpty(ffEmpty), .ffFull(ffFull), .ffCount(ffCount),
        .errClr(errClr), .frameErr(frameErr), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All stimulus keeps the invariant: we sit #1 after a rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        step(B);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(B);
        end
        rx = stop;
        step(B);
        rx = 1'b1;
    endtask

    task automatic read_one();
        rdEn = 1'b1;
        step(1);
        rdEn = 1'b0;
    endtask

    // Monitor: every accepted pop is scored against the oldest expected byte
    always @(negedge clk) begin
        if (rstB && rdEn && !ffEmpty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", rdData);
            end else begin
                check("pop_data", int'(rdData), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int k;
        // Reset state
        step(3);
        check("rst_empty", ffEmpty, 1);
        check("rst_full", ffFull, 0);
        check("rst_count", ffCount, 0);
        check("rst_ferr", frameErr, 0);
        check("rst_ovr", overrun, 0);
        rstB = 1'b1;
        step(5);

        // Single frame with latency measured from the pin start edge
        k = 0;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (k < 300) begin
                    @(posedge clk);
                    #1;
                    k++;
                    if (!ffEmpty) break;
                end
            end
        join
        check("a5_latency", k, B/2 + 8*B + B + 3);
        check("a5_data", rdData, 8'hA5);
        check("a5_count", ffCount, 1);
        check("a5_ferr", frameErr, 0);
        check("a5_ovr", overrun, 0);
        read_one();
        check("a5_empty_after", ffEmpty, 1);

        // Back-to-back frames
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        step(4);
        check("b2b_count", ffCount, 3);
        repeat (3) read_one();
        check("b2b_empty", ffEmpty, 1);

        // Glitch shorter than half a bit
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(40);
        check("glitch_count", ffCount, 0);
        check("glitch_ferr", frameErr, 0);

        // Framing error, clear, then a good frame
        send_frame(8'h3C, 1'b0);
        step(30);
        check("ferr_set", frameErr, 1);
        check("ferr_count", ffCount, 0);
        errClr = 1'b1;
        step(1);
        errClr = 1'b0;
        check("ferr_clr", frameErr, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        step(4);
        check("after_ferr_count", ffCount, 1);
        check("after_ferr_flag", frameErr, 0);
        read_one();

        // Overflow with no reads
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1);
        end
        step(4);
        check("full_flag", ffFull, 1);
        check("full_ovr_before", overrun, 0);
        send_frame(8'h14, 1'b1);
        step(4);
        check("ovr_set", overrun, 1);
        check("ovr_count", ffCount, 4);
        repeat (4) read_one();
        check("ovr_drain_empty", ffEmpty, 1);
        errClr = 1'b1;
        step(1);
        errClr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Full buffer with a pop in the 5th frame's push cycle
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send_frame(8'h10 + 8'(i), 1'b1);
        end
        step(4);
        check("full2_flag", ffFull, 1);
        exp_q.push_back(8'h14);
        fork
            send_frame(8'h14, 1'b1);
            begin
                step(B/2 + 8*B + B + 2);
                rdEn = 1'b1;
                step(1);
                rdEn = 1'b0;
            end
        join
        step(4);
        check("pushpop_count", ffCount, 4);
        check("pushpop_ovr", overrun, 0);
        check("pushpop_head", rdData, 8'h11);
        repeat (4) read_one();
        check("pushpop_empty", ffEmpty, 1);

        // Reset mid-frame with a byte and a flag pending
        send_frame(8'h5A, 1'b1);
        send_frame(8'h00, 1'b0);
        step(30);
        check("pre_rst_count", ffCount, 1);
        check("pre_rst_ferr", frameErr, 1);
        rx = 1'b0;
        step(B);
        rx = 1'b1;
        step(2*B);
        rstB = 1'b0;
        step(2);
        check("mid_rst_empty", ffEmpty, 1);
        check("mid_rst_full", ffFull, 0);
        check("mid_rst_count", ffCount, 0);
        check("mid_rst_ferr", frameErr, 0);
        check("mid_rst_ovr", overrun, 0);
        rstB = 1'b1;
        step(40);
        check("post_rst_count", ffCount, 0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        step(4);
        check("post_rst_42_count", ffCount, 1);
        check("post_rst_42_data", rdData, 8'h42);
        check("post_rst_ferr", frameErr, 0);
        read_one();
        step(2);
        check("final_empty", ffEmpty, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_buf.md
Name: uart_rx_buf

Overview:
- Serial UART receiver with integrated receive buffer: 8N1 frames in on `rx`, bytes out through a show-ahead FIFO read port.
- Receive-side counterpart of the buffered UART transmit path.
- Sits between the board pin and the core's MMIO/peripheral bus; software polls `ffEmpty` and pops bytes with `rdEn`.
- Sticky error flags report framing errors and buffer overruns.

Parameters:
- BAUD_CYCLE, 868, clk cycles per bit (115200 baud at 100 MHz); must be >= 8.
- DEPTH, 16, buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rstB  in  1  synchronous active-low reset, sampled on rising clk.
- rx  in  1  asynchronous serial input, idle high.
- rdEn  in  1  pop oldest byte; ignored when ffEmpty=1.
- rdData  out  8  oldest buffered byte, valid whenever ffEmpty=0.
- ffEmpty  out  1  buffer empty.
- ffFull  out  1  buffer holds DEPTH bytes.
- ffCount  out  $clog2(DEPTH)+1  number of buffered bytes.
- errClr  in  1  clears frameErr and overrun.
- frameErr  out  1  sticky: a stop bit sampled low.
- overrun  out  1  sticky: a good byte was dropped because the buffer was full.

Behaviour:
- Reset (rstB=0 at a clk edge):
  - Synchronizer flops load 1; FSM goes to IDLE; bit/baud counters clear.
  - FIFO pointers and count clear, so ffEmpty=1, ffFull=0, ffCount=0.
  - frameErr=0, overrun=0. rdData is don't-care while empty.
  - Reset mid-frame aborts the frame; the partial byte is never written.
- Input sync: two-flop synchronizer on `rx`. `rxs` denotes the second flop output; all decisions use `rxs`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rxs`=0, go to START with the baud counter cleared.
  - START: count BAUD_CYCLE/2 cycles (integer division) to reach the start-bit midpoint.
    - If `rxs`=1 at the midpoint: false start, return to IDLE with no other effect.
    - Otherwise go to DATA with the baud counter cleared.
  - DATA: sample `rxs` every BAUD_CYCLE cycles, 8 samples, LSB first, shifted into a shift register. After the 8th sample go to STOP.
  - STOP: after BAUD_CYCLE cycles, sample `rxs`.
    - `rxs`=1: the byte is good and is pushed this cycle.
    - `rxs`=0: the byte is discarded and frameErr is set.
    - In both cases return to IDLE immediately; no wait for the full stop bit, so back-to-back frames are supported.
    - With `rxs`=0, IDLE sees low at once. This is treated as a new start edge and re-validated at the START midpoint.
- Push timing:
  - The push occurs on the clk edge ending the stop-sample cycle.
  - From that edge: ffEmpty falls, ffCount increments, and rdData shows the byte if the buffer was empty.
  - Total latency from the stop-bit midpoint at pin `rx` is 2 sync cycles plus 1.
- FIFO:
  - Circular buffer with pointer wrap at DEPTH. Show-ahead: rdData = mem[rdPtr].
  - Pop when rdEn=1 and ffEmpty=0; rdPtr advances at the clk edge.
  - Push and pop in the same cycle: both happen and ffCount is unchanged. This applies when full too: the push is accepted because a slot frees that cycle.
  - Push when full without a pop: byte dropped, overrun set, buffer contents unchanged.
  - rdEn while empty: no pointer change, no error.
- Error flags:
  - Each flag is set on its event and held until errClr=1 or reset.
  - If a set event and errClr occur in the same cycle, set wins.
- ffFull = (ffCount==DEPTH). ffEmpty = (ffCount==0). Both are registered-consistent with ffCount.

Test Plan:
- BAUD_CYCLE=16, DEPTH=4. Send frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first).
  - Expected: ffEmpty falls exactly 16/2+8*16+16+3 cycles after the start edge at pin; rdData=0xA5; ffCount=1; no errors.
- Back-to-back frames 0x01, 0xFF, 0x80 with no idle gap, then rdEn pulses.
  - Expected: bytes read in order 0x01, 0xFF, 0x80; ffEmpty=1 after the third pop.
- Glitch: 4-cycle low pulse on `rx`.
  - Expected: false start, FSM returns to IDLE, ffCount stays 0, frameErr=0.
- Frame 0x3C with the stop bit held low.
  - Expected: frameErr=1, ffCount=0.
  - Then errClr pulse: frameErr=0. A following good frame 0x11 is received normally.
- Send 5 frames 0x10..0x14 with no reads.
  - Expected: ffFull=1 after the 4th; the 5th is dropped and overrun=1; reads return 0x10..0x13.
  - Repeat with rdEn asserted in the 5th frame's push cycle: 0x14 accepted, ffCount stays 4, overrun=0.
- Assert rstB=0 mid-DATA of frame 0x77, release, then send 0x42.
  - Expected: no partial byte is stored; only 0x42 is received; all outputs at reset values during reset.
